mem_arbiter: RTL and testbench

Two-port request arbiter sitting directly upstream of the Wishbone master: it merges the CPU data port (port 0) and instruction-fetch port (port 1) onto the single CPU-side memory interface of `wishbone_master`. It grants one port at a time and holds that port's registered request until the master acknowledges. It then routes the ack and read data back to the granted port only. Arbitration is round-robin by default, with an optional fixed priority for port 0.

---
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: merges the CPU data port (port 0) and the instruction-fetch
// port (port 1) onto the single CPU-side request interface of wishbone_master.
// One port owns the master from its grant until the master acknowledges.
// Ties are broken round-robin, or always toward port 0 when FIXED_PRIO is set.
module mem_arbiter #(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 16,
    parameter int FIXED_PRIO = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_p0_req,
    input  logic              i_p0_we,
    input  logic [ADDR_W-1:0] i_p0_addr,
    input  logic [DATA_W-1:0] i_p0_data,
    output logic [DATA_W-1:0] o_p0_data,
    output logic              o_p0_ack,
    input  logic              i_p1_req,
    input  logic              i_p1_we,
    input  logic [ADDR_W-1:0] i_p1_addr,
    input  logic [DATA_W-1:0] i_p1_data,
    output logic [DATA_W-1:0] o_p1_data,
    output logic              o_p1_ack,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_data,
    output logic              o_mem_next,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic              i_mem_ack
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_data_q, mem_data_d;
    logic                grant0, grant1;
    logic                ack0, ack1;

    // Decide which port (if any) wins the master this cycle; only IDLE grants
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE) begin
            if (i_p0_req && i_p1_req) begin
                if (FIXED_PRIO != 0) begin
                    grant0 = 1'b1;
                end else if (last_q) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end else if (i_p0_req) begin
                grant0 = 1'b1;
            end else if (i_p1_req) begin
                grant1 = 1'b1;
            end
        end
    end

    // Next-state logic: grant moves to BUSYn, the master's ack returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant0) begin
                    state_d = BUSY0;
                end else if (grant1) begin
                    state_d = BUSY1;
                end
            end
            BUSY0, BUSY1: begin
                if (i_mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Latch the granted port's request; hold it frozen until the ack drops req
    always_comb begin
        last_d     = last_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        if (grant0) begin
            mem_req_d  = 1'b1;
            mem_we_d   = i_p0_we;
            mem_addr_d = i_p0_addr;
            mem_data_d = i_p0_we ? i_p0_data : '0;
            last_d     = 1'b0;
        end else if (grant1) begin
            mem_req_d  = 1'b1;
            mem_we_d   = i_p1_we;
            mem_addr_d = i_p1_addr;
            mem_data_d = i_p1_we ? i_p1_data : '0;
            last_d     = 1'b1;
        end else if ((state_q != IDLE) && i_mem_ack) begin
            mem_req_d  = 1'b0;
        end
    end

    // Route the master's ack and read data straight back to the owning port only
    always_comb begin
        ack0      = (state_q == BUSY0) && i_mem_ack;
        ack1      = (state_q == BUSY1) && i_mem_ack;
        o_p0_ack  = ack0;
        o_p1_ack  = ack1;
        o_p0_data = (ack0 && !mem_we_q) ? i_mem_data : '0;
        o_p1_data = (ack1 && !mem_we_q) ? i_mem_data : '0;
    end

    assign o_mem_req  = mem_req_q;
    assign o_mem_we   = mem_we_q;
    assign o_mem_addr = mem_addr_q;
    assign o_mem_data = mem_data_q;
    assign o_mem_next = 1'b0;

    // State and request registers; reset abandons any transaction in flight
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. Two instances share the port-side stimulus: one
// round-robin, one fixed-priority. Each has its own small Wishbone-master model.
// Expected transactions go into a scoreboard queue in predicted grant order
// and are checked off as the selected instance acks its ports.
module tb_mem_arbiter;

   localparam int AW = 24;
   localparam int DW = 16;
   localparam int MASTER_LAT = 3;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic          hasAlt;
      logic [AW-1:0] altAddr;
   } ReqItem;

   typedef struct {
      int            port;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rdata;
   } ExpItem;

   logic          clock = 1'b0;
   logic          reset;

   logic          portReq [2];
   logic          portWe [2];
   logic [AW-1:0] portAddr [2];
   logic [DW-1:0] portWdata [2];

   logic          pAck [2][2];
   logic [DW-1:0] pRdata [2][2];
   logic          memReq [2];
   logic          memWe [2];
   logic          memNext [2];
   logic [AW-1:0] memAddr [2];
   logic [DW-1:0] memWdata [2];
   logic [DW-1:0] memRdata [2];
   logic          memAck [2];

   int            masterCnt [2];
   logic          portActive [2];
   ReqItem        portQ [2][$];
   ExpItem        expQ [$];
   logic          inject;
   int            dutSel;
   int            cycle;
   int            checkCount = 0;
   int            errorCount = 0;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) dutRr (
      .i_clk(clock), .i_rst(reset),
      .i_p0_req(portReq[0]), .i_p0_we(portWe[0]), .i_p0_addr(portAddr[0]), .i_p0_data(portWdata[0]),
      .o_p0_data(pRdata[0][0]), .o_p0_ack(pAck[0][0]),
      .i_p1_req(portReq[1]), .i_p1_we(portWe[1]), .i_p1_addr(portAddr[1]), .i_p1_data(portWdata[1]),
      .o_p1_data(pRdata[0][1]), .o_p1_ack(pAck[0][1]),
      .o_mem_req(memReq[0]), .o_mem_we(memWe[0]), .o_mem_addr(memAddr[0]), .o_mem_data(memWdata[0]),
      .o_mem_next(memNext[0]), .i_mem_data(memRdata[0]), .i_mem_ack(memAck[0])
   );

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) dutFp (
      .i_clk(clock), .i_rst(reset),
      .i_p0_req(portReq[0]), .i_p0_we(portWe[0]), .i_p0_addr(portAddr[0]), .i_p0_data(portWdata[0]),
      .o_p0_data(pRdata[1][0]), .o_p0_ack(pAck[1][0]),
      .i_p1_req(portReq[1]), .i_p1_we(portWe[1]), .i_p1_addr(portAddr[1]), .i_p1_data(portWdata[1]),
      .o_p1_data(pRdata[1][1]), .o_p1_ack(pAck[1][1]),
      .o_mem_req(memReq[1]), .o_mem_we(memWe[1]), .o_mem_addr(memAddr[1]), .o_mem_data(memWdata[1]),
      .o_mem_next(memNext[1]), .i_mem_data(memRdata[1]), .i_mem_ack(memAck[1])
   );

   // Free-running clock, 10 time units per period
   always #5 clock = ~clock;

   // Read data the master model returns for a given address
   function automatic logic [DW-1:0] respData(input logic [AW-1:0] addr);
      if (addr == 24'h000123) return 16'hBEEF;
      return addr[15:0] ^ 16'h5A5A;
   endfunction

   // Count one comparison and report it when observed differs from expected
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Queue a request on a port and push its expected completion to the scoreboard
   task automatic applyStimulus(input int port, input logic we, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input logic hasAlt, input logic [AW-1:0] altAddr);
      ReqItem r;
      ExpItem e;
      r.we = we; r.addr = addr; r.wdata = wdata; r.hasAlt = hasAlt; r.altAddr = altAddr;
      portQ[port].push_back(r);
      e.port = port; e.we = we; e.addr = addr; e.wdata = wdata;
      e.rdata = we ? 16'h0000 : respData(addr);
      expQ.push_back(e);
   endtask

   // Master model: acks MASTER_LAT cycles into a request with a one-cycle pulse
   task automatic masterStep();
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            memAck[i] = 1'b0;
            masterCnt[i] = 0;
         end else if (memAck[i]) begin
            memAck[i] = 1'b0;
            masterCnt[i] = 0;
         end else if (inject) begin
            memAck[i] = 1'b1;
         end else if (memReq[i]) begin
            masterCnt[i]++;
            if (masterCnt[i] == MASTER_LAT) memAck[i] = 1'b1;
         end else begin
            masterCnt[i] = 0;
         end
         if (!memAck[i]) memRdata[i] = 16'hDEAD;
         else if (inject) memRdata[i] = 16'h7777;
         else memRdata[i] = respData(memAddr[i]);
      end
   endtask

   // Scoreboard side: every port ack must match the next expected transaction
   task automatic monitorStep();
      int     d;
      logic   a0, a1;
      ExpItem e;
      d  = dutSel;
      a0 = pAck[d][0];
      a1 = pAck[d][1];
      if (a0 || a1) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpectedAck", 64'({a1, a0}), 64'(0));
         end else begin
            e = expQ.pop_front();
            checkOutput("ackPort", 64'({a1, a0}), (e.port == 1) ? 64'(2) : 64'(1));
            checkOutput("ackData", 64'(pRdata[d][e.port]), 64'(e.rdata));
            checkOutput("otherData", 64'(pRdata[d][1 - e.port]), 64'(0));
            checkOutput("memAddr", 64'(memAddr[d]), 64'(e.addr));
            checkOutput("memWe", 64'(memWe[d]), 64'(e.we));
            checkOutput("memWdata", 64'(memWdata[d]), e.we ? 64'(e.wdata) : 64'(0));
            checkOutput("memReqAtAck", 64'(memReq[d]), 64'(1));
         end
      end else begin
         checkOutput("quietData", 64'({pRdata[d][0], pRdata[d][1]}), 64'(0));
         if (memReq[d] && expQ.size() > 0) checkOutput("holdAddr", 64'(memAddr[d]), 64'(expQ[0].addr));
      end
   endtask

   // Port drivers: hold each request until acked, then present the next one
   task automatic driverStep();
      ReqItem done;
      for (int p = 0; p < 2; p++) begin
         if (portActive[p] && pAck[dutSel][p]) begin
            done = portQ[p].pop_front();
            portActive[p] = 1'b0;
         end
         if (portActive[p] && portQ[p][0].hasAlt && memReq[dutSel]) portAddr[p] = portQ[p][0].altAddr;
         if (!portActive[p]) begin
            if (portQ[p].size() > 0) begin
               portReq[p]    = 1'b1;
               portWe[p]     = portQ[p][0].we;
               portAddr[p]   = portQ[p][0].addr;
               portWdata[p]  = portQ[p][0].wdata;
               portActive[p] = 1'b1;
            end else begin
               portReq[p] = 1'b0;
            end
         end
      end
   endtask

   // One cycle: master reacts at the falling edge, then checks and drivers
   task automatic tick();
      @(negedge clock);
      cycle++;
      masterStep();
      #1;
      monitorStep();
      driverStep();
   endtask

   // Run until the scoreboard empties, bounded by a cycle budget
   task automatic drain(input int maxCycles);
      int n = 0;
      while (expQ.size() > 0 && n < maxCycles) begin
         tick();
         n++;
      end
      checkOutput("drained", 64'(expQ.size()), 64'(0));
   endtask

   // All outputs of both instances at their reset values
   task automatic checkResetValues(input string tag);
      for (int i = 0; i < 2; i++) begin
         checkOutput({tag, "Ctrl"}, 64'({memReq[i], memWe[i], memNext[i], pAck[i][0], pAck[i][1]}), 64'(0));
         checkOutput({tag, "Addr"}, 64'(memAddr[i]), 64'(0));
         checkOutput({tag, "Wdata"}, 64'(memWdata[i]), 64'(0));
         checkOutput({tag, "Rdata"}, 64'({pRdata[i][0], pRdata[i][1]}), 64'(0));
      end
   endtask

   // Clear stimulus and scoreboard, then hold reset for a few cycles
   task automatic doReset();
      reset = 1'b1;
      inject = 1'b0;
      expQ.delete();
      for (int p = 0; p < 2; p++) begin
         portQ[p].delete();
         portActive[p] = 1'b0;
         portReq[p] = 1'b0;
      end
      repeat (3) tick();
      reset = 1'b0;
   endtask

   // Main test sequence
   initial begin
      int n;
      reset = 1'b1;
      inject = 1'b0;
      dutSel = 0;
      cycle = 0;
      for (int i = 0; i < 2; i++) begin
         portReq[i] = 1'b0; portWe[i] = 1'b0; portAddr[i] = '0; portWdata[i] = '0;
         portActive[i] = 1'b0; memAck[i] = 1'b0; memRdata[i] = 16'hDEAD; masterCnt[i] = 0;
      end
      doReset();
      checkResetValues("reset");

      $display("[TB] single port-0 read");
      applyStimulus(0, 1'b0, 24'h000123, 16'h0000, 1'b0, 24'h0);
      tick();
      checkOutput("reqBeforeGrant", 64'(memReq[0]), 64'(0));
      tick();
      checkOutput("reqAfterGrant", 64'(memReq[0]), 64'(1));
      drain(20);
      tick();
      checkOutput("ackPulseWidth", 64'({pAck[0][1], pAck[0][0]}), 64'(0));

      $display("[TB] port-1 write");
      applyStimulus(1, 1'b1, 24'h00FF00, 16'h1234, 1'b0, 24'h0);
      drain(20);

      $display("[TB] port-0 address change while busy");
      applyStimulus(0, 1'b0, 24'h000321, 16'h0000, 1'b1, 24'h000555);
      drain(20);

      $display("[TB] spurious ack while idle");
      tick();
      inject = 1'b1;
      tick();
      checkOutput("spurAck", 64'({pAck[0][1], pAck[0][0]}), 64'(0));
      checkOutput("spurReq", 64'(memReq[0]), 64'(0));
      inject = 1'b0;
      tick();
      checkOutput("spurIdle", 64'(memReq[0]), 64'(0));
      applyStimulus(0, 1'b0, 24'h000777, 16'h0000, 1'b0, 24'h0);
      drain(20);

      $display("[TB] round-robin, both ports requesting");
      doReset();
      dutSel = 0;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 1'b0, 24'h001000 + 24'(k), 16'h0000, 1'b0, 24'h0);
         applyStimulus(1, k[0], 24'h002000 + 24'(k), 16'hC000 + 16'(k), 1'b0, 24'h0);
      end
      drain(100);

      $display("[TB] fixed priority, both ports requesting");
      doReset();
      dutSel = 1;
      for (int k = 0; k < 6; k++) begin
         applyStimulus(0, 1'b0, 24'h003000 + 24'(k), 16'h0000, 1'b0, 24'h0);
      end
      applyStimulus(1, 1'b0, 24'h004000, 16'h0000, 1'b0, 24'h0);
      drain(150);

      $display("[TB] reset during BUSY1");
      doReset();
      dutSel = 0;
      applyStimulus(1, 1'b0, 24'h0ABCDE, 16'h0000, 1'b0, 24'h0);
      n = 0;
      while (!memReq[0] && n < 20) begin
         tick();
         n++;
      end
      checkOutput("busy1Reached", 64'(memReq[0]), 64'(1));
      reset = 1'b1;
      tick();
      checkResetValues("midReset");
      checkOutput("noAckOnReset", 64'(pAck[0][1]), 64'(0));
      expQ.delete();
      for (int p = 0; p < 2; p++) begin
         portQ[p].delete();
         portActive[p] = 1'b0;
         portReq[p] = 1'b0;
      end
      tick();
      reset = 1'b0;
      applyStimulus(0, 1'b0, 24'h000BBB, 16'h0000, 1'b0, 24'h0);
      applyStimulus(1, 1'b0, 24'h000AAA, 16'h0000, 1'b0, 24'h0);
      drain(40);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
